// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Data-memory request/ready bus between the MEM stage and data memory.
//   req   : request, held until the cycle ready is seen
//   we    : 1 = write, 0 = read
//   addr  : word-aligned byte address
//   wdata : store data
//   ready : memory completes the request this cycle
//   rdata : load data, valid with ready on a read
// master = MEM stage side, slave = memory side.
// ---------------------------------------------------------------------------
interface mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ready, rdata);
    modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// MEM stage of a 5-stage MIPS pipeline. Takes the EX/MEM bundle, performs
// lw/sw over the dmem request/ready bus and drives the registered MEM/WB
// bundle. Holds upstream with stall_o while an access is pending, inserting
// bubbles into MEM/WB, and squashes misaligned word accesses (align_err_o).
// Ports:
//   clk_i, rst_n_i           : clock, asynchronous active-low reset
//   valid_i, *_i controls    : EX/MEM bundle (RegWrite/MemtoReg/MemRead/MemWrite)
//   ALU_result_i             : ALU result / effective address
//   write_data_i, dest_reg_i : store data, destination register
//   dmem                     : data-memory bus (master side)
//   stall_o                  : hold IF/ID/EX and EX/MEM this cycle
//   align_err_o              : one-cycle pulse, misaligned access squashed
//   RegWrite_o .. dest_reg_o : registered MEM/WB bundle
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [DATA_W-1:0] ALU_result_i,
    input  logic [DATA_W-1:0] write_data_i,
    input  logic [REG_AW-1:0] dest_reg_i,
    mem_stage_if.master       dmem,
    output logic              stall_o,
    output logic              align_err_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic [DATA_W-1:0] read_data_o,
    output logic [DATA_W-1:0] ALU_result_o,
    output logic [REG_AW-1:0] dest_reg_o
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_q, state_d;

    // Instruction captured for the duration of an access
    logic                cap_we_q, cap_we_d;
    logic                cap_rw_q, cap_rw_d;
    logic                cap_m2r_q, cap_m2r_d;
    logic [DATA_W-1:0]   cap_addr_q, cap_addr_d;
    logic [DATA_W-1:0]   cap_wdata_q, cap_wdata_d;
    logic [REG_AW-1:0]   cap_dest_q, cap_dest_d;

    // MEM/WB bundle
    logic                wb_rw_q, wb_rw_d;
    logic                wb_m2r_q, wb_m2r_d;
    logic [DATA_W-1:0]   wb_rdata_q, wb_rdata_d;
    logic [DATA_W-1:0]   wb_alu_q, wb_alu_d;
    logic [REG_AW-1:0]   wb_dest_q, wb_dest_d;
    logic                align_err_q, align_err_d;

    logic                memop;
    logic                misal;
    logic                stall_c;
    logic                req_c;
    logic                we_c;
    logic [DATA_W-1:0]   addr_c;
    logic [DATA_W-1:0]   wdata_c;

    assign memop = valid_i & (MemRead_i | MemWrite_i);
    assign misal = |ALU_result_i[1:0];

    always_comb begin
        state_d     = state_q;
        cap_we_d    = cap_we_q;
        cap_rw_d    = cap_rw_q;
        cap_m2r_d   = cap_m2r_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        cap_dest_d  = cap_dest_q;
        // MEM/WB is reloaded every edge; a bubble unless overridden below
        wb_rw_d     = 1'b0;
        wb_m2r_d    = 1'b0;
        wb_rdata_d  = '0;
        wb_alu_d    = '0;
        wb_dest_d   = '0;
        align_err_d = 1'b0;
        stall_c     = 1'b0;
        req_c       = 1'b0;
        we_c        = 1'b0;
        addr_c      = '0;
        wdata_c     = '0;

        case (state_q)
            IDLE: begin
                if (!memop) begin
                    wb_rw_d   = RegWrite_i & valid_i;
                    wb_m2r_d  = MemtoReg_i;
                    wb_alu_d  = ALU_result_i;
                    wb_dest_d = dest_reg_i;
                end else if (misal) begin
                    align_err_d = 1'b1;
                end else begin
                    stall_c     = 1'b1;
                    // MemWrite wins when both MemRead and MemWrite are set
                    cap_we_d    = MemWrite_i;
                    cap_rw_d    = RegWrite_i;
                    cap_m2r_d   = MemtoReg_i;
                    cap_addr_d  = ALU_result_i;
                    cap_wdata_d = write_data_i;
                    cap_dest_d  = dest_reg_i;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                req_c   = 1'b1;
                we_c    = cap_we_q;
                addr_c  = cap_addr_q;
                wdata_c = cap_wdata_q;
                // Upstream advances on the completing edge
                stall_c = !dmem.ready;
                if (dmem.ready) begin
                    wb_rw_d    = cap_rw_q;
                    wb_m2r_d   = cap_m2r_q;
                    wb_rdata_d = cap_we_q ? '0 : dmem.rdata;
                    wb_alu_d   = cap_addr_q;
                    wb_dest_d  = cap_dest_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cap_we_q    <= 1'b0;
            cap_rw_q    <= 1'b0;
            cap_m2r_q   <= 1'b0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            cap_dest_q  <= '0;
            wb_rw_q     <= 1'b0;
            wb_m2r_q    <= 1'b0;
            wb_rdata_q  <= '0;
            wb_alu_q    <= '0;
            wb_dest_q   <= '0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_we_q    <= cap_we_d;
            cap_rw_q    <= cap_rw_d;
            cap_m2r_q   <= cap_m2r_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
            cap_dest_q  <= cap_dest_d;
            wb_rw_q     <= wb_rw_d;
            wb_m2r_q    <= wb_m2r_d;
            wb_rdata_q  <= wb_rdata_d;
            wb_alu_q    <= wb_alu_d;
            wb_dest_q   <= wb_dest_d;
            align_err_q <= align_err_d;
        end
    end

    // stall_o is combinational from the inputs in IDLE, so it is gated with
    // the reset to keep every output low while reset is held.
    assign stall_o      = stall_c & rst_n_i;
    assign dmem.req     = req_c;
    assign dmem.we      = we_c;
    assign dmem.addr    = addr_c;
    assign dmem.wdata   = wdata_c;
    assign align_err_o  = align_err_q;
    assign RegWrite_o   = wb_rw_q;
    assign MemtoReg_o   = wb_m2r_q;
    assign read_data_o  = wb_rdata_q;
    assign ALU_result_o = wb_alu_q;
    assign dest_reg_o   = wb_dest_q;
endmodule
